instr_fetch_queue: RTL and testbench

- Front end of the pipelined core: produces the instruction stream that the decode stage consumes (opcode, funct3, funct7 fields are sliced from instr_out downstream).
- Generates sequential fetch addresses, issues them to instruction memory over a valid/ready request channel, and buffers in-order responses in a DEPTH-entry FIFO.
- Presents instructions to decode with a valid/ready handshake.
- Handles PC redirects from the execute stage (branch/jump) by flushing buffered and in-flight instructions.

---
 rtl/instr_fetch_queue.sv | 127 ++++++++++++
 tb/tb_instr_fetch_queue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: sequential PC generation, memory request channel,
// in-order response buffering and redirect flush, presented to decode via valid/ready.
module instr_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4,
   parameter int          CNT_W    = 3
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   output logic [31:0] instr_pcplus4
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] outst_q, outst_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]      data_mem_q [DEPTH];
   logic [31:0]      pc_mem_q   [DEPTH];
   logic [CNT_W:0]   occupancy;
   logic [31:0]      redirect_target;
   logic             accept;
   logic             capture;
   logic             pop;

   // Valid/ready: a transfer happens on any cycle where valid and ready are both
   // high; imem responses carry no backpressure and arrive in request order.
   // Requests reserve a FIFO slot, so captured responses can never overflow it.
   assign occupancy       = {1'b0, count_q} + {1'b0, outst_q};
   assign imem_req_valid  = ~reset & ~redirect & (occupancy < (CNT_W+1)'(DEPTH));
   assign imem_req_addr   = fetch_pc_q;
   assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

   assign accept  = imem_req_valid & imem_req_ready;
   assign capture = imem_rsp_valid & (drop_q == '0) & ~redirect;
   assign pop     = instr_valid & instr_ready & ~redirect;

   assign instr_valid = (count_q != '0);
   assign instr_out   = data_mem_q[rd_ptr_q];
   assign instr_pc    = pc_mem_q[rd_ptr_q];
   // Head is don't-care when empty; gating keeps pcplus4 at zero out of reset.
   assign instr_pcplus4 = instr_valid ? (instr_pc + 32'd4) : 32'h0;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      drop_d     = drop_q;
      count_d    = count_q + CNT_W'(capture) - CNT_W'(pop);
      outst_d    = outst_q + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
      if (accept) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end
      // Responses after the last redirect are consecutive words, so the PC of
      // the next captured response is a running tag rather than a stored queue.
      if (capture) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
         rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (imem_rsp_valid && (drop_q != '0)) begin
         drop_d = drop_q - CNT_W'(1);
      end
      if (redirect) begin
         fetch_pc_d = redirect_target;
         rsp_pc_d   = redirect_target;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         drop_d     = outst_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         count_q    <= '0;
         outst_q    <= '0;
         drop_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_mem_q[i] <= 32'h0;
            pc_mem_q[i]   <= 32'h0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         count_q    <= count_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         if (capture) begin
            data_mem_q[wr_ptr_q] <= imem_rsp_data;
            pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
         end
      end
   end

   a_rsp_has_outstanding : assert property (@(posedge clk) disable iff (reset)
      imem_rsp_valid |-> (outst_q != '0));
   a_count_bound : assert property (@(posedge clk) disable iff (reset)
      count_q <= CNT_W'(DEPTH));
   a_drop_bound : assert property (@(posedge clk) disable iff (reset)
      drop_q <= outst_q);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: randomized memory/decode behaviour checked against a
// queue-based model of the expected instruction stream and request addresses.
module tb_instr_fetch_queue;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] addr;
      int          due;
      int          epoch;
   } mem_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic [31:0] instr_pcplus4;

   // Model state: words buffered for decode {data, pc}, requests in memory, next fetch PC.
   logic [63:0] exp_q[$];
   mem_t        mem_q[$];
   logic [31:0] m_fetch_pc = 32'h0;
   int          epoch = 0;
   int          cyc = 0;
   int          n_acc = 0;

   int rq_pct = 100, ir_pct = 100, lat_min = 1, lat_max = 1;
   logic        last_rv, last_iv;
   logic [31:0] last_ipc;

   int n_tests = 0;
   int n_fail = 0;

   instr_fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH), .CNT_W(3)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_out      (instr_out),
      .instr_pc       (instr_pc),
      .instr_pcplus4  (instr_pcplus4)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset          = 1'b1;
      redirect       = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b0;
      instr_ready    = 1'b0;
      #1;
      chk("rst_req_valid", imem_req_valid, 1'b0);
      chk("rst_instr_valid", instr_valid, 1'b0);
      chk("rst_instr_out", instr_out, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
      chk("rst_instr_pcplus4", instr_pcplus4, 32'h0);
      exp_q.delete();
      mem_q.delete();
      m_fetch_pc = 32'h0;
      epoch++;
      n_acc = 0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // One clock cycle: drive inputs, check outputs against the model, then advance the model.
   task automatic step(input bit do_redir, input logic [31:0] rpc);
      logic exp_rv;
      bit   rsp;
      mem_t m;
      @(negedge clk);
      redirect       = do_redir;
      redirect_pc    = rpc;
      imem_req_ready = ($urandom_range(99) < rq_pct);
      instr_ready    = ($urandom_range(99) < ir_pct);
      rsp            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      imem_rsp_valid = rsp;
      imem_rsp_data  = rsp ? imem_word(mem_q[0].addr) : $urandom;
      #1;
      exp_rv = !do_redir && ((exp_q.size() + mem_q.size()) < DEPTH);
      chk("req_valid", imem_req_valid, exp_rv);
      if (exp_rv) chk("req_addr", imem_req_addr, m_fetch_pc);
      chk("instr_valid", instr_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         chk("instr_out", instr_out, exp_q[0][63:32]);
         chk("instr_pc", instr_pc, exp_q[0][31:0]);
         chk("instr_pcplus4", instr_pcplus4, exp_q[0][31:0] + 32'd4);
      end
      last_rv  = imem_req_valid;
      last_iv  = instr_valid;
      last_ipc = instr_pc;
      if (exp_q.size() != 0 && instr_ready && !do_redir) void'(exp_q.pop_front());
      if (rsp) begin
         m = mem_q.pop_front();
         if (!do_redir && m.epoch == epoch) exp_q.push_back({imem_word(m.addr), m.addr});
      end
      if (exp_rv && imem_req_ready) begin
         m.addr  = m_fetch_pc;
         m.due   = cyc + $urandom_range(lat_max, lat_min);
         m.epoch = epoch;
         mem_q.push_back(m);
         m_fetch_pc = m_fetch_pc + 32'd4;
         n_acc++;
      end
      if (do_redir) begin
         exp_q.delete();
         epoch++;
         m_fetch_pc = rpc & 32'hFFFF_FFFC;
      end
      cyc++;
   endtask

   initial begin
      int n_seen;
      int guard;

      // Streaming with a 1-cycle memory and a never-stalling decoder.
      do_reset();
      rq_pct = 100; ir_pct = 100; lat_min = 1; lat_max = 1;
      repeat (30) step(1'b0, 32'h0);

      // Decode stalled from reset: exactly DEPTH requests, then one pop frees one slot.
      do_reset();
      ir_pct = 0;
      n_seen = 0;
      repeat (10) begin
         step(1'b0, 32'h0);
         if (last_rv) n_seen++;
      end
      chk("stall_req_count", n_seen, DEPTH);
      ir_pct = 100;
      step(1'b0, 32'h0);
      ir_pct = 0;
      repeat (3) step(1'b0, 32'h0);

      // Redirect with three requests in flight to a 3-cycle memory.
      do_reset();
      ir_pct = 100; lat_min = 3; lat_max = 3;
      guard = 0;
      while (mem_q.size() != 3 && guard < 20) begin
         step(1'b0, 32'h0);
         guard++;
      end
      chk("inflight3_reached", mem_q.size() == 3, 1'b1);
      step(1'b1, 32'h0000_0100);
      guard = 0;
      do begin
         step(1'b0, 32'h0);
         guard++;
      end while (!last_iv && guard < 20);
      chk("first_pc_after_redirect", last_ipc, 32'h0000_0100);
      repeat (5) step(1'b0, 32'h0);

      // Unaligned redirect target and address wrap at the top of memory.
      lat_min = 1; lat_max = 2;
      step(1'b1, 32'h0000_0203);
      repeat (6) step(1'b0, 32'h0);
      step(1'b1, 32'hFFFF_FFF4);
      repeat (10) step(1'b0, 32'h0);
      step(1'b1, 32'h0000_0040);
      step(1'b1, 32'h0000_0080);
      repeat (8) step(1'b0, 32'h0);

      // Randomized traffic, stalls and redirects.
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 1500; i++) begin
         rq_pct = $urandom_range(100, 40);
         ir_pct = $urandom_range(100, 30);
         if ($urandom_range(99) < 6) step(1'b1, $urandom);
         else                        step(1'b0, 32'h0);
      end
      repeat (10) step(1'b0, 32'h0);

      // Reset with two buffered words and one request still in flight.
      do_reset();
      ir_pct = 0; lat_min = 3; lat_max = 3;
      guard = 0;
      while (!(exp_q.size() == 2 && mem_q.size() == 1) && guard < 30) begin
         rq_pct = (n_acc < 3) ? 100 : 0;
         step(1'b0, 32'h0);
         guard++;
      end
      chk("two_buffered_one_inflight", (exp_q.size() == 2 && mem_q.size() == 1), 1'b1);
      do_reset();
      rq_pct = 100; ir_pct = 100; lat_min = 1; lat_max = 1;
      repeat (12) step(1'b0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
